// File: rtl/dcache_linefill.sv
// dcache_linefill: miss-handling engine between the data cache and the on-chip RAM (OCM).
//
// On an accepted miss the engine optionally reads the dirty victim line out of the dcache
// data RAM and writes it back to OCM. It then reads the new line from OCM, writes it into the
// dcache data and tag RAMs, and returns it for forwarding with a one-cycle resp_valid pulse.
// The cache is direct-mapped with 32 sets and one 128-bit word per line.
//
// Ports:
//   CLK, RSTN                    clock, asynchronous active-low reset
//   req_valid/req_ready          miss handshake; accepted when both are high
//   req_index/req_tag            set index and tag of the missing line
//   req_wb/req_vtag              victim dirty flag and victim tag
//   resp_valid/resp_data         fill-complete pulse and the filled line
//   ocm_req/ocm_gnt              OCM arbitration; an access happens in a cycle with req & gnt
//   ocm_cena/wena/aa/qa          OCM port A (read only)
//   ocm_cenb/wenb/ab/db          OCM port B (write only)
//   dm_cen/wen/a/d/q             dcache data RAM
//   dt_cenb/ab/db                dcache tag RAM write port
//   fill_cnt/wb_cnt              saturating event counters

module dcache_linefill #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_index,
    input  logic [6:0]       req_tag,
    input  logic             req_wb,
    input  logic [6:0]       req_vtag,
    output logic             resp_valid,
    output logic [127:0]     resp_data,
    output logic             ocm_req,
    input  logic             ocm_gnt,
    output logic             ocm_cena,
    output logic             ocm_wena,
    output logic [11:0]      ocm_aa,
    input  logic [127:0]     ocm_qa,
    output logic             ocm_cenb,
    output logic             ocm_wenb,
    output logic [11:0]      ocm_ab,
    output logic [127:0]     ocm_db,
    output logic             dm_cen,
    output logic [15:0]      dm_wen,
    output logic [4:0]       dm_a,
    output logic [127:0]     dm_d,
    input  logic [127:0]     dm_q,
    output logic             dt_cenb,
    output logic [4:0]       dt_ab,
    output logic [6:0]       dt_db,
    output logic [CNT_W-1:0] fill_cnt,
    output logic [CNT_W-1:0] wb_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StRdVic,
        StWbWr,
        StFillRd,
        StFillWr,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Latched request fields; all RAM pins decode from these, never from req_*.
    logic [4:0]       index_q;
    logic [6:0]       tag_q;
    logic [6:0]       vtag_q;

    logic [127:0]     victim_q;
    // Set once the victim has been captured so a stalled writeback keeps driving stable data.
    logic             victim_held_q;
    logic [127:0]     resp_data_q;
    logic [CNT_W-1:0] fill_cnt_q;
    logic [CNT_W-1:0] wb_cnt_q;

    logic accept;
    assign accept = (state_q == StIdle) && req_valid;

    // ---------------------------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= StIdle;
            index_q       <= '0;
            tag_q         <= '0;
            vtag_q        <= '0;
            victim_q      <= '0;
            victim_held_q <= 1'b0;
            resp_data_q   <= '0;
            fill_cnt_q    <= '0;
            wb_cnt_q      <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                index_q <= req_index;
                tag_q   <= req_tag;
                vtag_q  <= req_vtag;
            end

            // dm_q is only valid in the first writeback cycle, so hold a copy for stalls.
            if (state_q == StWbWr) begin
                if (!victim_held_q) begin
                    victim_q <= dm_q;
                end
                victim_held_q <= !ocm_gnt;
            end else begin
                victim_held_q <= 1'b0;
            end

            if (state_q == StFillWr) begin
                resp_data_q <= ocm_qa;
            end

            if (state_q == StWbWr && ocm_gnt && wb_cnt_q != '1) begin
                wb_cnt_q <= wb_cnt_q + CNT_W'(1);
            end

            if (state_q == StDone && fill_cnt_q != '1) begin
                fill_cnt_q <= fill_cnt_q + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Next state and pin decode
    // ---------------------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ocm_req    = 1'b0;
        ocm_cena   = 1'b1;
        ocm_wena   = 1'b1;
        ocm_aa     = '0;
        ocm_cenb   = 1'b1;
        ocm_wenb   = 1'b1;
        ocm_ab     = '0;
        ocm_db     = '0;
        dm_cen     = 1'b1;
        dm_wen     = 16'hFFFF;
        dm_a       = '0;
        dm_d       = '0;
        dt_cenb    = 1'b1;
        dt_ab      = '0;
        dt_db      = '0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_wb ? StRdVic : StFillRd;
                end
            end

            StRdVic: begin
                dm_cen  = 1'b0;
                dm_a    = index_q;
                state_d = StWbWr;
            end

            StWbWr: begin
                ocm_req  = 1'b1;
                ocm_cenb = 1'b0;
                ocm_wenb = 1'b0;
                ocm_ab   = {vtag_q, index_q};
                ocm_db   = victim_held_q ? victim_q : dm_q;
                if (ocm_gnt) begin
                    state_d = StFillRd;
                end
            end

            StFillRd: begin
                ocm_req  = 1'b1;
                ocm_cena = 1'b0;
                ocm_aa   = {tag_q, index_q};
                if (ocm_gnt) begin
                    state_d = StFillWr;
                end
            end

            StFillWr: begin
                dm_cen  = 1'b0;
                dm_wen  = 16'h0000;
                dm_a    = index_q;
                dm_d    = ocm_qa;
                dt_cenb = 1'b0;
                dt_ab   = index_q;
                dt_db   = tag_q;
                state_d = StDone;
            end

            StDone: begin
                resp_valid = 1'b1;
                state_d    = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign resp_data = resp_data_q;
    assign fill_cnt  = fill_cnt_q;
    assign wb_cnt    = wb_cnt_q;

endmodule

// File: tb/tb_dcache_linefill.sv
// Testbench for dcache_linefill: behavioural OCM / data RAM / tag RAM models, a directed
// driver pushing expected responses into a scoreboard queue, and a monitor that pops and
// compares on every resp_valid pulse.

module tb_dcache_linefill;

    localparam int unsigned CNT_W = 2;

    logic             CLK;
    logic             RSTN;
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       req_index;
    logic [6:0]       req_tag;
    logic             req_wb;
    logic [6:0]       req_vtag;
    logic             resp_valid;
    logic [127:0]     resp_data;
    logic             ocm_req;
    logic             ocm_gnt;
    logic             ocm_cena;
    logic             ocm_wena;
    logic [11:0]      ocm_aa;
    logic [127:0]     ocm_qa;
    logic             ocm_cenb;
    logic             ocm_wenb;
    logic [11:0]      ocm_ab;
    logic [127:0]     ocm_db;
    logic             dm_cen;
    logic [15:0]      dm_wen;
    logic [4:0]       dm_a;
    logic [127:0]     dm_d;
    logic [127:0]     dm_q;
    logic             dt_cenb;
    logic [4:0]       dt_ab;
    logic [6:0]       dt_db;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] wb_cnt;

    dcache_linefill #(.CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_index  (req_index),
        .req_tag    (req_tag),
        .req_wb     (req_wb),
        .req_vtag   (req_vtag),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .ocm_req    (ocm_req),
        .ocm_gnt    (ocm_gnt),
        .ocm_cena   (ocm_cena),
        .ocm_wena   (ocm_wena),
        .ocm_aa     (ocm_aa),
        .ocm_qa     (ocm_qa),
        .ocm_cenb   (ocm_cenb),
        .ocm_wenb   (ocm_wenb),
        .ocm_ab     (ocm_ab),
        .ocm_db     (ocm_db),
        .dm_cen     (dm_cen),
        .dm_wen     (dm_wen),
        .dm_a       (dm_a),
        .dm_d       (dm_d),
        .dm_q       (dm_q),
        .dt_cenb    (dt_cenb),
        .dt_ab      (dt_ab),
        .dt_db      (dt_db),
        .fill_cnt   (fill_cnt),
        .wb_cnt     (wb_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_resp = 0;
    int ocm_wr_cnt = 0;
    int strobes = 0;

    typedef struct {
        logic [127:0] data;
        int           delta;  // expected resp cycle minus first post-accept cycle; -1 = skip
        int           acc;
    } exp_t;
    exp_t sb_q[$];

    // Stall budgets consumed by the grant model, with the pin values expected while stalled.
    int           stall_wb   = 0;
    int           stall_fill = 0;
    logic [11:0]  stall_ab   = '0;
    logic [127:0] stall_db   = '0;
    logic [11:0]  stall_aa   = '0;

    logic [127:0] ocm_mem [0:4095];
    logic [127:0] dm_mem  [0:31];
    logic [6:0]   dt_mem  [0:31];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ memory models
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (ocm_req && ocm_gnt && !ocm_cena) ocm_qa <= ocm_mem[ocm_aa];
        if (ocm_req && ocm_gnt && !ocm_cenb && !ocm_wenb) begin
            ocm_mem[ocm_ab] <= ocm_db;
            ocm_wr_cnt      <= ocm_wr_cnt + 1;
        end
        if (!dm_cen) begin
            if (&dm_wen) dm_q <= dm_mem[dm_a];
            for (int b = 0; b < 16; b++)
                if (!dm_wen[b]) dm_mem[dm_a][b*8 +: 8] <= dm_d[b*8 +: 8];
        end
        if (!dt_cenb) dt_mem[dt_ab] <= dt_db;
        if (!ocm_cena || !ocm_cenb || !dm_cen || !dt_cenb) strobes <= strobes + 1;
    end

    // ------------------------------------------------------------------ grant model
    always @(negedge CLK) begin
        if (ocm_req && !ocm_cenb && stall_wb > 0) begin
            ocm_gnt  = 1'b0;
            stall_wb = stall_wb - 1;
            chk("stall_ocm_ab", {116'd0, ocm_ab}, {116'd0, stall_ab});
            chk("stall_ocm_db", ocm_db, stall_db);
        end else if (ocm_req && !ocm_cena && stall_fill > 0) begin
            ocm_gnt    = 1'b0;
            stall_fill = stall_fill - 1;
            chk("stall_ocm_aa", {116'd0, ocm_aa}, {116'd0, stall_aa});
        end else begin
            ocm_gnt = 1'b1;
        end
    end

    // ------------------------------------------------------------------ scoreboard monitor
    always @(negedge CLK) begin
        if (RSTN === 1'b1 && resp_valid === 1'b1) begin
            n_resp <= n_resp + 1;
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("resp_data", resp_data, e.data);
                if (e.delta >= 0) chk("resp_latency", 128'(cyc - e.acc), 128'(e.delta));
            end
        end
    end

    // ------------------------------------------------------------------ driver helpers
    task automatic issue(input logic [4:0] idx, input logic [6:0] tg, input logic wb,
                         input logic [6:0] vt, input logic [127:0] exp, input int delta);
        int n = 0;
        @(negedge CLK);
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        req_index = idx;
        req_tag   = tg;
        req_wb    = wb;
        req_vtag  = vt;
        req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        sb_q.push_back('{data: exp, delta: delta, acc: cyc});
    endtask

    task automatic wait_resp(input int target);
        int n = 0;
        while (n_resp < target && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n_resp < target) chk("resp_timeout", 128'(n_resp), 128'(target));
    endtask

    task automatic chk_idle_pins(input string nm);
        chk({nm, "_cens"}, {124'd0, ocm_cena, ocm_cenb, dm_cen, dt_cenb}, 128'hF);
        chk({nm, "_wens"}, {111'd0, ocm_wena, ocm_wenb, dm_wen}, 128'h3FFFF);
        chk({nm, "_ready"}, {126'd0, req_ready, ocm_req}, 128'h2);
        chk({nm, "_cnts"}, {124'd0, fill_cnt, wb_cnt}, 128'h0);
    endtask

    localparam logic [127:0] DA5 = {16{8'hA5}};
    localparam logic [127:0] DDE = {8{16'hDEAD}};
    localparam logic [127:0] F2  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] V3  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] F3  = 128'hCAFE_F00D_0000_0001_BEEF_0000_1234_5678;
    localparam logic [127:0] V4  = 128'h7F7F_0000_FFFF_0101_A5A5_5A5A_C3C3_3C3C;
    localparam logic [127:0] V5  = 128'h5555_5555_5555_5555_AAAA_AAAA_AAAA_AAAA;
    localparam logic [127:0] F6  = 128'h6666_0000_6666_0000_6666_0000_6666_0006;

    initial begin
        int n;
        int last_cyc;
        int snap;

        RSTN      = 1'b1;
        req_valid = 1'b0;
        req_index = '0;
        req_tag   = '0;
        req_wb    = 1'b0;
        req_vtag  = '0;
        ocm_gnt   = 1'b1;
        for (int i = 0; i < 4096; i++) ocm_mem[i] <= '0;
        for (int i = 0; i < 32; i++) begin
            dm_mem[i] <= '0;
            dt_mem[i] <= '0;
        end
        ocm_mem[12'h245] <= DA5;
        ocm_mem[12'h103] <= F2;
        dm_mem[3]        <= DDE;
        dm_mem[10]       <= V3;
        ocm_mem[{7'h21, 5'd10}] <= F3;
        dm_mem[31]       <= V4;
        ocm_mem[12'hFFF] <= 128'h1;
        dm_mem[12]       <= V5;
        ocm_mem[{7'h33, 5'd7}] <= F6;

        #1 RSTN = 1'b0;
        #1;
        chk_idle_pins("reset");
        chk("reset_resp", {127'd0, resp_valid}, 128'd0);
        chk("reset_resp_data", resp_data, 128'd0);
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;

        // Clean miss
        issue(5'd5, 7'h12, 1'b0, 7'h00, DA5, 2);
        wait_resp(1);
        chk("t1_dm_mem", dm_mem[5], DA5);
        chk("t1_dt_mem", {121'd0, dt_mem[5]}, 128'h12);
        chk("t1_cnts", {124'd0, fill_cnt, wb_cnt}, {124'd0, 2'd1, 2'd0});

        // Dirty miss: victim to 0x083, fill from 0x103
        issue(5'd3, 7'h08, 1'b1, 7'h04, F2, 4);
        wait_resp(2);
        chk("t2_ocm_wb", ocm_mem[12'h083], DDE);
        chk("t2_dm_mem", dm_mem[3], F2);
        chk("t2_dt_mem", {121'd0, dt_mem[3]}, 128'h08);
        chk("t2_cnts", {124'd0, fill_cnt, wb_cnt}, {124'd0, 2'd2, 2'd1});
        chk("t2_wr_cnt", 128'(ocm_wr_cnt), 128'd1);

        // Grant stall: 4 cycles in writeback, 2 in fill read
        stall_ab   = {7'h20, 5'd10};
        stall_db   = V3;
        stall_aa   = {7'h21, 5'd10};
        stall_wb   = 4;
        stall_fill = 2;
        issue(5'd10, 7'h21, 1'b1, 7'h20, F3, 10);
        wait_resp(3);
        repeat (4) @(negedge CLK);
        chk("t3_resp_count", 128'(n_resp), 128'd3);
        chk("t3_ocm_wb", ocm_mem[{7'h20, 5'd10}], V3);
        chk("t3_wr_cnt", 128'(ocm_wr_cnt), 128'd2);
        chk("t3_cnts", {124'd0, fill_cnt, wb_cnt}, {124'd0, 2'd3, 2'd2});

        // Same line: writeback then fill of the very same OCM word
        issue(5'd31, 7'h7F, 1'b1, 7'h7F, V4, 4);
        wait_resp(4);
        chk("t4_ocm", ocm_mem[12'hFFF], V4);
        chk("t4_dm_mem", dm_mem[31], V4);
        chk("t4_cnts_sat", {124'd0, fill_cnt, wb_cnt}, {124'd0, 2'd3, 2'd3});

        // Reset while stalled in writeback
        stall_ab = {7'h05, 5'd12};
        stall_db = V5;
        stall_wb = 3;
        issue(5'd12, 7'h06, 1'b1, 7'h05, 128'd0, -1);
        n = 0;
        while (!(ocm_req && !ocm_cenb) && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("t5_reached_wb", {127'd0, ocm_req && !ocm_cenb}, 128'd1);
        #2 RSTN = 1'b0;
        #1;
        chk_idle_pins("t5_reset");
        sb_q.delete();
        stall_wb = 0;
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        snap = strobes;
        repeat (10) @(negedge CLK);
        chk("t5_no_strobes", 128'(strobes), 128'(snap));
        chk("t5_no_wb", ocm_mem[{7'h05, 5'd12}], 128'd0);
        chk("t5_wr_cnt", 128'(ocm_wr_cnt), 128'd3);

        // Back-to-back with req_valid held high; counter saturates at 3
        for (int i = 0; i < 5; i++) sb_q.push_back('{data: F6, delta: -1, acc: 0});
        req_index = 5'd7;
        req_tag   = 7'h33;
        req_wb    = 1'b0;
        req_vtag  = 7'h00;
        req_valid = 1'b1;
        last_cyc  = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (resp_valid !== 1'b1 && n < 20) begin
                @(negedge CLK);
                n++;
            end
            chk("t6_pulse", {127'd0, resp_valid}, 128'd1);
            chk("t6_ready_in_done", {127'd0, req_ready}, 128'd0);
            if (k > 0) chk("t6_gap", 128'(cyc - last_cyc), 128'd4);
            last_cyc = cyc;
            if (k == 4) req_valid = 1'b0;
            @(negedge CLK);
            chk("t6_ready_after", {127'd0, req_ready}, 128'd1);
        end
        repeat (4) @(negedge CLK);
        chk("t6_cnts", {124'd0, fill_cnt, wb_cnt}, {124'd0, 2'd3, 2'd0});
        chk("t6_dt_mem", {121'd0, dt_mem[7]}, 128'h33);
        chk("final_resp_count", 128'(n_resp), 128'd9);
        chk("final_sb_empty", 128'(sb_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
